// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester skid FIFOs feeding two registered
// broadcast ports, granted in round-robin order starting at rr_ptr.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 6,
    parameter int ROB_W     = 6,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*32-1:0]      req_value,
    input  logic [NUM_REQ*ROB_W-1:0]   req_rob,
    input  logic [NUM_REQ-1:0]         req_has_rd,
    output logic [NUM_PORTS-1:0]       bcast_valid,
    output logic [NUM_PORTS*TAG_W-1:0] bcast_tag,
    output logic [NUM_PORTS*32-1:0]    bcast_value,
    output logic [NUM_PORTS*ROB_W-1:0] bcast_rob,
    output logic [NUM_PORTS-1:0]       bcast_has_rd,
    output logic [NUM_REQ*2-1:0]       fifo_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
        logic [ROB_W-1:0] rob;
        logic             has_rd;
    } entry_t;

    entry_t           mem   [NUM_REQ][DEPTH];
    logic [PTR_W-1:0] head  [NUM_REQ];
    logic [PTR_W-1:0] tail  [NUM_REQ];
    logic [1:0]       count [NUM_REQ];
    entry_t           in_ent[NUM_REQ];

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel0;
    logic [IDX_W-1:0]   sel1;
    logic [IDX_W-1:0]   scan_idx;
    logic               found0;
    logic               found1;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    entry_t             out0;
    entry_t             out1;

    // Ready comes only from registered occupancy, so there is no pop-to-ready path.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign in_ent[gi].tag    = req_tag[gi*TAG_W +: TAG_W];
        assign in_ent[gi].value  = req_value[gi*32 +: 32];
        assign in_ent[gi].rob    = req_rob[gi*ROB_W +: ROB_W];
        assign in_ent[gi].has_rd = req_has_rd[gi];
        assign req_ready[gi]     = reset && (count[gi] != FULL);
        assign push[gi]          = req_valid[gi] && req_ready[gi];
        assign fifo_count[gi*2 +: 2] = count[gi];
    end

    // The scan index wraps through the natural overflow of IDX_W bits (NUM_REQ is 4).
    always_comb begin
        found0   = 1'b0;
        found1   = 1'b0;
        sel0     = '0;
        sel1     = '0;
        scan_idx = '0;
        pop      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + IDX_W'(k);
            if (count[scan_idx] != 2'd0) begin
                if (!found0) begin
                    found0 = 1'b1;
                    sel0   = scan_idx;
                end else if (!found1) begin
                    found1 = 1'b1;
                    sel1   = scan_idx;
                end
            end
        end
        if (found0) pop[sel0] = 1'b1;
        if (found1) pop[sel1] = 1'b1;
        out0 = found0 ? mem[sel0][head[sel0]] : '0;
        out1 = found1 ? mem[sel1][head[sel1]] : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) mem[i][tail[i]] <= in_ent[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr       <= '0;
            bcast_valid  <= '0;
            bcast_tag    <= '0;
            bcast_value  <= '0;
            bcast_rob    <= '0;
            bcast_has_rd <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) tail[i] <= tail[i] + PTR_W'(1);
                if (pop[i])  head[i] <= head[i] + PTR_W'(1);
                count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
            bcast_valid  <= {found1, found0};
            bcast_tag    <= {out1.tag, out0.tag};
            bcast_value  <= {out1.value, out0.value};
            bcast_rob    <= {out1.rob, out0.rob};
            bcast_has_rd <= {out1.has_rd, out0.has_rd};
            if (found1) begin
                rr_ptr <= sel1 + IDX_W'(1);
            end else if (found0) begin
                rr_ptr <= sel0 + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based reference model predicts every
// broadcast cycle, and the expectations are checked one cycle later from a scoreboard.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [23:0]  req_tag = '0;
    logic [127:0] req_value = '0;
    logic [23:0]  req_rob = '0;
    logic [3:0]   req_has_rd = '0;
    logic [1:0]   bcast_valid;
    logic [11:0]  bcast_tag;
    logic [63:0]  bcast_value;
    logic [11:0]  bcast_rob;
    logic [1:0]   bcast_has_rd;
    logic [7:0]   fifo_count;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
        logic [5:0]  rob;
        logic        has_rd;
    } ent_t;

    typedef struct packed {
        logic [1:0]  valid;
        logic [11:0] tag;
        logic [63:0] value;
        logic [11:0] rob;
        logic [1:0]  has_rd;
    } bc_t;

    ent_t       mq [4][$];
    bc_t        exp_q[$];
    logic [1:0] m_rr = '0;
    logic [3:0] last_acc;
    int         vectors = 0;
    int         miscompares = 0;
    int         next_tag2 = 20;

    cdb_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_value(req_value), .req_rob(req_rob), .req_has_rd(req_has_rd),
        .bcast_valid(bcast_valid), .bcast_tag(bcast_tag), .bcast_value(bcast_value),
        .bcast_rob(bcast_rob), .bcast_has_rd(bcast_has_rd), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [5:0] tag, input logic [31:0] value,
                           input logic [5:0] rob, input logic has_rd);
        req_valid[i]         = 1'b1;
        req_tag[i*6 +: 6]    = tag;
        req_value[i*32 +: 32] = value;
        req_rob[i*6 +: 6]    = rob;
        req_has_rd[i]        = has_rd;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        exp_q.delete();
        m_rr = '0;
    endtask

    // One clock: predict grants from the pre-edge queues, then push accepted requests.
    task automatic tick();
        logic [3:0] exp_ready;
        bc_t        e;
        ent_t       ent;
        int         found;
        logic [1:0] idx;
        logic [1:0] last;
        for (int i = 0; i < 4; i++) exp_ready[i] = (mq[i].size() != 2);
        check_output("req_ready", 128'(req_ready), 128'(exp_ready));
        last_acc = req_valid & exp_ready;
        e = '0;
        found = 0;
        last = m_rr;
        for (int k = 0; k < 4; k++) begin
            idx = m_rr + 2'(k);
            if (found < 2 && mq[idx].size() > 0) begin
                ent = mq[idx].pop_front();
                if (found == 0) begin
                    e.valid[0] = 1'b1; e.tag[5:0] = ent.tag; e.value[31:0] = ent.value;
                    e.rob[5:0] = ent.rob; e.has_rd[0] = ent.has_rd;
                end else begin
                    e.valid[1] = 1'b1; e.tag[11:6] = ent.tag; e.value[63:32] = ent.value;
                    e.rob[11:6] = ent.rob; e.has_rd[1] = ent.has_rd;
                end
                found++;
                last = idx;
            end
        end
        if (found > 0) m_rr = last + 2'd1;
        for (int i = 0; i < 4; i++) begin
            if (last_acc[i]) begin
                ent.tag    = req_tag[i*6 +: 6];
                ent.value  = req_value[i*32 +: 32];
                ent.rob    = req_rob[i*6 +: 6];
                ent.has_rd = req_has_rd[i];
                mq[i].push_back(ent);
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_output("bcast_valid", 128'(bcast_valid), 128'(e.valid));
        check_output("bcast_tag", 128'(bcast_tag), 128'(e.tag));
        check_output("bcast_value", 128'(bcast_value), 128'(e.value));
        check_output("bcast_rob", 128'(bcast_rob), 128'(e.rob));
        check_output("bcast_has_rd", 128'(bcast_has_rd), 128'(e.has_rd));
        for (int i = 0; i < 4; i++)
            check_output($sformatf("fifo_count%0d", i), 128'(fifo_count[i*2 +: 2]), 128'(mq[i].size()));
    endtask

    task automatic watch_tags();
        for (int p = 0; p < 2; p++) begin
            if (bcast_valid[p] === 1'b1 && bcast_tag[p*6 +: 6] >= 6'd20 && bcast_tag[p*6 +: 6] <= 6'd25) begin
                check_output("bp_order", 128'(bcast_tag[p*6 +: 6]), 128'(next_tag2));
                next_tag2++;
            end
        end
    endtask

    initial begin
        int   t[4];
        int   cycles;
        logic saw_low;
        logic saw_drop;
        logic [1:0] pre_cnt;
        logic pre_rdy;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_bcast_valid", 128'(bcast_valid), 128'(0));
        check_output("rst_ready_low", 128'(req_ready), 128'(0));
        reset = 1'b1;
        #1;
        check_output("rst_ready_high", 128'(req_ready), 128'(4'b1111));
        check_output("rst_count", 128'(fifo_count), 128'(0));

        // Four simultaneous requests from rr_ptr = 0.
        for (int i = 0; i < 4; i++) set_req(i, 6'(10 + i), 32'hA000_0000 + 32'(i), 6'(i + 1), 1'b1);
        tick();
        req_valid = '0;
        tick();
        check_output("four_p0", 128'(bcast_tag[5:0]), 128'(10));
        check_output("four_p1", 128'(bcast_tag[11:6]), 128'(11));
        tick();
        check_output("four_p0b", 128'(bcast_tag[5:0]), 128'(12));
        check_output("four_p1b", 128'(bcast_tag[11:6]), 128'(13));
        tick();

        // Single requester.
        set_req(0, 6'd5, 32'hDEAD_BEEF, 6'd3, 1'b1);
        tick();
        req_valid = '0;
        tick();
        check_output("single_valid", 128'(bcast_valid), 128'(2'b01));
        check_output("single_tag", 128'(bcast_tag[5:0]), 128'(5));
        check_output("single_value", 128'(bcast_value[31:0]), 128'(32'hDEAD_BEEF));
        check_output("single_rob", 128'(bcast_rob[5:0]), 128'(3));
        check_output("single_has_rd", 128'(bcast_has_rd[0]), 128'(1));
        tick();
        check_output("single_idle", 128'(bcast_valid), 128'(0));

        // Store completion from the LSQ without a destination register.
        set_req(3, 6'd9, 32'h0000_0777, 6'd7, 1'b0);
        tick();
        req_valid = '0;
        tick();
        check_output("nord_valid", 128'(bcast_valid[0]), 128'(1));
        check_output("nord_has_rd", 128'(bcast_has_rd[0]), 128'(0));
        check_output("nord_rob", 128'(bcast_rob[5:0]), 128'(7));
        tick();

        // Backpressure: everyone pushes, requester 2 sends tags 20..25 and must hold when not ready.
        t[0] = 40; t[1] = 48; t[2] = 20; t[3] = 56;
        cycles = 0;
        saw_low = 1'b0;
        while (t[2] < 26 && cycles < 40) begin
            req_valid = '0;
            for (int i = 0; i < 4; i++)
                set_req(i, 6'(t[i]), 32'h1000_0000 + 32'(t[i]), 6'(i * 8 + cycles % 8), 1'b1);
            if (req_ready[2] === 1'b0) saw_low = 1'b1;
            tick();
            watch_tags();
            for (int i = 0; i < 4; i++) begin
                if (last_acc[i]) begin
                    if (i == 2) t[2]++;
                    else t[i] = (t[i] & ~7) + ((t[i] + 1) & 7);
                end
            end
            cycles++;
        end
        check_output("bp_done", 128'(t[2]), 128'(26));
        check_output("bp_ready_low", 128'(saw_low), 128'(1));
        req_valid = '0;
        repeat (6) begin
            tick();
            watch_tags();
        end
        check_output("bp_order_count", 128'(next_tag2), 128'(26));

        // Full FIFO1 granted while requester 1 keeps asking.
        for (int i = 0; i < 4; i++) set_req(i, 6'(32 + i), 32'h2000_0000 + 32'(i), 6'(i), 1'b1);
        tick();
        req_valid = '0;
        t[1] = 30;
        saw_drop = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_req(1, 6'(t[1]), 32'h3000_0000 + 32'(c), 6'(c), 1'b1);
            pre_cnt = fifo_count[3:2];
            pre_rdy = req_ready[1];
            tick();
            if (last_acc[1]) t[1]++;
            if (pre_cnt == 2'd2) begin
                check_output("full_ready", 128'(pre_rdy), 128'(0));
                if (fifo_count[3:2] == 2'd1) begin
                    check_output("full_ready_next", 128'(req_ready[1]), 128'(1));
                    saw_drop = 1'b1;
                end
            end
        end
        check_output("full_drop_seen", 128'(saw_drop), 128'(1));
        req_valid = '0;
        repeat (5) tick();

        // Reset mid-stream with FIFO0 holding data.
        set_req(0, 6'd1, 32'h0000_0001, 6'd1, 1'b1);
        tick();
        set_req(0, 6'd2, 32'h0000_0002, 6'd2, 1'b1);
        tick();
        req_valid = '0;
        reset = 1'b0;
        #1;
        model_reset();
        check_output("mid_bcast_valid", 128'(bcast_valid), 128'(0));
        check_output("mid_bcast_tag", 128'(bcast_tag), 128'(0));
        check_output("mid_count", 128'(fifo_count), 128'(0));
        check_output("mid_ready_low", 128'(req_ready), 128'(0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("mid_ready_high", 128'(req_ready), 128'(4'b1111));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
